pcs_tx_oset_sequencer: RTL and testbench
========================================

# pcs_tx_oset_sequencer

Ordered-set sequencer and source arbiter for the 1000BASE-X PCS transmit path. Each GTX_CLK cycle it emits one 8-bit code-group plus a K flag to the 8B/10B encoder. It chooses between three sources: auto-negotiation configuration sets (/C1/,/C2/), idle sets (/I1/,/I2/) and GMII frame data (/S/, /D/, /V/, /T/, /R/). It enforces even/odd ordered-set alignment and sits between the GMII transmit interface and the encoder.

## Interface
- IDLE_I2_ONLY, 0: when 1, every idle is /I2/ and tx_disparity is ignored.
- GTX_CLK  in  1  transmit clock; all state updates on its rising edge.
- mr_main_reset  in  1  reset; synchronous, active-high.
- xmit  in  2  mode: 00 CONFIGURATION, 01 IDLE, 10 DATA, 11 treated as IDLE.
- TXD  in  8  GMII transmit data.
- TX_EN  in  1  GMII transmit enable.
- TX_ER  in  1  GMII transmit error.
- tx_config_reg  in  16  auto-negotiation base/next page.
- tx_disparity  in  1  encoder running disparity after the current code-group (1 = positive).
- tx_code  out  8  code-group to the encoder.
- tx_is_k  out  1  1 = tx_code is a K code.
- tx_even  out  1  1 = tx_code occupies an even slot.
- tx_pkt_active  out  1  1 from /S/ through the final /R/.

## Operation
- Code constants: K28.5=BC, D21.5=B5, D2.2=42, D5.6=C5, D16.2=50, /S/=K27.7 FB, /T/=K29.7 FD, /R/=K23.7 F7, /V/=K30.7 FE.
- tx_even toggles every cycle. Every ordered set starts on an even slot.
- States:
  - CFG_K, CFG_D, CFG_LO, CFG_HI.
  - IDLE_K, IDLE_D.
  - SOP, DATA.
  - EOP_T, EOP_R, EOP_R2.
- Mode decision: made only at an even slot that ends the current set. The mode is the xmit value sampled in that cycle.
- CONFIGURATION:
  - Emits BC, then B5 (/C1/) or 42 (/C2/), then cfg[7:0], then cfg[15:8].
  - /C1/ and /C2/ alternate, starting with /C1/ after entry.
  - tx_config_reg is captured at CFG_K. A change mid-set does not affect the set in progress.
- IDLE, or DATA with no frame: emits BC, then the idle D code.
  - Idle D code is C5 (/I1/) if tx_disparity=1 at the K cycle, else 50 (/I2/).
  - In DATA, the first idle after /T/R/ uses this same rule.
- Frame start (DATA only): TX_EN rising is detected while the sequencer is in IDLE.
  - If the next output slot is even: /S/ replaces the first TX_EN byte.
  - If the next output slot is odd: IDLE_D completes, and /S/ replaces the second TX_EN byte. The first preamble byte is dropped.
  - A frame already in progress when xmit becomes DATA (TX_EN already high) is not started. Idles continue until TX_EN has been low for at least one cycle.
- DATA state: tx_code = TXD registered with tx_is_k=0. If TX_ER=1 with TX_EN=1, emits FE with tx_is_k=1 instead.
- Frame end: on the first cycle with TX_EN=0, emit /T/, then /R/.
  - If the /R/ is on an even slot, a second /R/ (EOP_R2) follows so that the next idle starts even.
  - Then return to IDLE.
- xmit leaves DATA mid-frame: the frame is terminated with /T/R/(/R/), then the new mode is taken at the next even boundary.
- Config to IDLE/DATA: the current 4-code-group /C/ set always completes.

## Timing
- Reset values:
  - tx_code=BC, tx_is_k=1, tx_even=1, tx_pkt_active=0.
  - State IDLE_K, next /C/ set is /C1/.
- First cycle after reset release: odd slot, emits the idle D code (reset output counts as the even half).
- Latency: TXD/TX_EN/TX_ER sampled at edge n drive tx_code at edge n+1. All outputs are registered.
- Reset asserted mid-frame or mid-config: outputs take reset values at the next edge. No /T/ is emitted.
- TX_EN falling in the same cycle xmit changes: frame end takes priority. The mode change is applied after the trailing /R/.
- A one-cycle TX_EN pulse gives /S/ /T/ /R/(/R/) with no data.

## Structure
- Package pcs_pkg holds:
  - the code-group constants;
  - the xmit encodings;
  - the sequencer state enumeration, shared with the receive-side sync/receive blocks.
- Flat FSM plus the even/odd toggle and the C1/C2 toggle. No sub-module.

## Test plan
- Reset, then xmit=00, tx_config_reg=16'h01A0: expect BC B5 A0 01 BC 42 A0 01 repeating, with tx_even starting 1 at the first BC.
- xmit=10, tx_disparity=0, idle: expect BC 50 pairs. Set tx_disparity=1: expect BC C5.
- xmit=10, 8-byte frame 55×7 D5, TX_EN rising so the output is even: expect FB 55 55 55 55 55 55 D5 FD F7, then BC. Repeat with odd alignment: expect one idle D byte, then FB, with one 55 dropped.
- Frame with TX_ER=1 on byte 3: expect FE with tx_is_k=1 in that slot. Odd-length frame: expect FD F7 F7 so that BC lands on an even slot.
- Switch xmit 10→00 mid-frame: expect /T/R/ termination, then BC B5 on an even slot. Assert reset mid-frame: expect BC with tx_is_k=1 and tx_pkt_active=0 on the next edge.

Source files
------------

// File: rtl/pcs_pkg.sv
// rtl/pcs_pkg.sv - 1000BASE-X PCS code-groups, xmit encodings and sequencer states
// Shared by the transmit sequencer and the receive-side sync/receive blocks.
package pcs_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D21_5 = 8'hB5;
  localparam logic [7:0] D2_2  = 8'h42;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K30_7 = 8'hFE;

  localparam logic [1:0] XMIT_CONFIG = 2'b00;
  localparam logic [1:0] XMIT_IDLE   = 2'b01;
  localparam logic [1:0] XMIT_DATA   = 2'b10;

  typedef enum logic [3:0] {
    ST_CFG_K,
    ST_CFG_D,
    ST_CFG_LO,
    ST_CFG_HI,
    ST_IDLE_K,
    ST_IDLE_D,
    ST_SOP,
    ST_DATA,
    ST_EOP_T,
    ST_EOP_R,
    ST_EOP_R2
  } seq_state_e;

  // The reserved encoding 11 behaves as IDLE.
  function automatic logic [1:0] xmit_mode(input logic [1:0] x);
    return (x == 2'b11) ? XMIT_IDLE : x;
  endfunction

  function automatic logic [7:0] idle_d_code(input logic disp, input logic i2_only);
    return (disp && !i2_only) ? D5_6 : D16_2;
  endfunction

endpackage

// File: rtl/pcs_tx_oset_sequencer.sv
// rtl/pcs_tx_oset_sequencer.sv - 1000BASE-X PCS transmit ordered-set sequencer and source arbiter
// state_q names the code-group currently on tx_code; every output is registered.
module pcs_tx_oset_sequencer
  import pcs_pkg::*;
#(
  parameter bit IDLE_I2_ONLY = 1'b0
) (
  input  logic        GTX_CLK,
  input  logic        mr_main_reset,
  input  logic [1:0]  xmit,
  input  logic [7:0]  TXD,
  input  logic        TX_EN,
  input  logic        TX_ER,
  input  logic [15:0] tx_config_reg,
  input  logic        tx_disparity,
  output logic [7:0]  tx_code,
  output logic        tx_is_k,
  output logic        tx_even,
  output logic        tx_pkt_active
);

  seq_state_e  state_q, state_d;
  logic [7:0]  code_q, code_d;
  logic        is_k_q, is_k_d;
  logic        even_q;
  logic        pkt_q, pkt_d;
  logic [15:0] cfg_q, cfg_d;
  logic        c2_q, c2_d;
  logic        pend_q, pend_d;
  logic        tx_en_q;

  logic [1:0]  mode;
  logic        tx_en_rise;
  logic        set_end;

  assign mode       = xmit_mode(xmit);
  assign tx_en_rise = TX_EN && !tx_en_q;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    is_k_d  = 1'b0;
    cfg_d   = cfg_q;
    c2_d    = c2_q;
    pend_d  = 1'b0;
    set_end = 1'b0;
    case (state_q)
      ST_CFG_K: begin
        state_d = ST_CFG_D;
        code_d  = c2_q ? D2_2 : D21_5;
        c2_d    = ~c2_q;
        cfg_d   = tx_config_reg;
      end
      ST_CFG_D: begin
        state_d = ST_CFG_LO;
        code_d  = cfg_q[7:0];
      end
      ST_CFG_LO: begin
        state_d = ST_CFG_HI;
        code_d  = cfg_q[15:8];
      end
      ST_IDLE_K: begin
        state_d = ST_IDLE_D;
        code_d  = idle_d_code(tx_disparity, IDLE_I2_ONLY);
        // A rise seen on the odd half is honoured one byte later, at the even slot.
        pend_d  = tx_en_rise && (mode == XMIT_DATA);
      end
      ST_IDLE_D: begin
        if ((mode == XMIT_DATA) && TX_EN && (tx_en_rise || pend_q)) begin
          state_d = ST_SOP;
          code_d  = K27_7;
          is_k_d  = 1'b1;
        end else begin
          set_end = 1'b1;
        end
      end
      ST_SOP, ST_DATA: begin
        if (!TX_EN || (mode != XMIT_DATA)) begin
          state_d = ST_EOP_T;
          code_d  = K29_7;
          is_k_d  = 1'b1;
        end else if (TX_ER) begin
          state_d = ST_DATA;
          code_d  = K30_7;
          is_k_d  = 1'b1;
        end else begin
          state_d = ST_DATA;
          code_d  = TXD;
        end
      end
      ST_EOP_T: begin
        state_d = ST_EOP_R;
        code_d  = K23_7;
        is_k_d  = 1'b1;
      end
      ST_EOP_R: begin
        if (even_q) begin
          state_d = ST_EOP_R2;
          code_d  = K23_7;
          is_k_d  = 1'b1;
        end else begin
          set_end = 1'b1;
        end
      end
      default: set_end = 1'b1;
    endcase

    if (set_end) begin
      code_d = K28_5;
      is_k_d = 1'b1;
      if (mode == XMIT_CONFIG) begin
        state_d = ST_CFG_K;
      end else begin
        state_d = ST_IDLE_K;
        c2_d    = 1'b0;
      end
    end

    pkt_d = state_d inside {ST_SOP, ST_DATA, ST_EOP_T, ST_EOP_R, ST_EOP_R2};
  end

  always_ff @(posedge GTX_CLK) begin
    if (mr_main_reset) begin
      state_q <= ST_IDLE_K;
      code_q  <= K28_5;
      is_k_q  <= 1'b1;
      even_q  <= 1'b1;
      pkt_q   <= 1'b0;
      cfg_q   <= '0;
      c2_q    <= 1'b0;
      pend_q  <= 1'b0;
      tx_en_q <= 1'b1;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      is_k_q  <= is_k_d;
      even_q  <= ~even_q;
      pkt_q   <= pkt_d;
      cfg_q   <= cfg_d;
      c2_q    <= c2_d;
      pend_q  <= pend_d;
      tx_en_q <= TX_EN;
    end
  end

  assign tx_code       = code_q;
  assign tx_is_k       = is_k_q;
  assign tx_even       = even_q;
  assign tx_pkt_active = pkt_q;

endmodule

// File: tb/tb_pcs_tx_oset_sequencer.sv
// tb/tb_pcs_tx_oset_sequencer.sv - self-checking bench for pcs_tx_oset_sequencer
// A queue-of-ordered-sets model predicts every output; directed literals pin the model.
module tb_pcs_tx_oset_sequencer;

  logic        GTX_CLK = 1'b0;
  logic        mr_main_reset;
  logic [1:0]  xmit;
  logic [7:0]  TXD;
  logic        TX_EN;
  logic        TX_ER;
  logic [15:0] tx_config_reg;
  logic        tx_disparity;
  logic [7:0]  tx_code;
  logic        tx_is_k;
  logic        tx_even;
  logic        tx_pkt_active;

  pcs_tx_oset_sequencer #(.IDLE_I2_ONLY(1'b0)) dut (
    .GTX_CLK       (GTX_CLK),
    .mr_main_reset (mr_main_reset),
    .xmit          (xmit),
    .TXD           (TXD),
    .TX_EN         (TX_EN),
    .TX_ER         (TX_ER),
    .tx_config_reg (tx_config_reg),
    .tx_disparity  (tx_disparity),
    .tx_code       (tx_code),
    .tx_is_k       (tx_is_k),
    .tx_even       (tx_even),
    .tx_pkt_active (tx_pkt_active)
  );

  always #5 GTX_CLK = ~GTX_CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_k_code(input logic [7:0] c);
    return c inside {8'hBC, 8'hFB, 8'hFD, 8'hF7, 8'hFE};
  endfunction

  // Model: the rest of the current ordered set waits in mq; markers resolve late-bound fields.
  localparam logic [2:0] E_LIT = 3'd0, E_IDLED = 3'd1, E_CFGC = 3'd2, E_LO = 3'd3, E_HI = 3'd4;
  typedef struct packed {
    logic [7:0] code;
    logic       k;
    logic       pkt;
    logic [2:0] kind;
  } ent_t;

  ent_t        mq[$];
  bit          chk_en = 1'b0;
  logic [7:0]  m_code;
  logic        m_k, m_even, m_pkt;
  logic        m_c2, m_prev_en, m_pend, m_frame;
  logic [15:0] m_cfg;

  task automatic model_step();
    ent_t       e;
    logic [1:0] mode;
    logic       rise, npend;
    if (mr_main_reset) begin
      mq.delete();
      mq.push_back('{8'h00, 1'b0, 1'b0, E_IDLED});
      m_code = 8'hBC; m_k = 1'b1; m_even = 1'b1; m_pkt = 1'b0;
      m_c2 = 1'b0; m_prev_en = 1'b1; m_pend = 1'b0; m_frame = 1'b0;
      chk_en = 1'b1;
      return;
    end
    mode  = (xmit == 2'b11) ? 2'b01 : xmit;
    rise  = TX_EN && !m_prev_en;
    npend = 1'b0;
    if (mq.size() != 0) begin
      e = mq.pop_front();
      m_k = e.k;
      m_pkt = e.pkt;
      case (e.kind)
        E_IDLED: begin
          m_code = tx_disparity ? 8'hC5 : 8'h50;
          npend  = rise && (mode == 2'b10);
        end
        E_CFGC: begin
          m_code = e.code;
          m_cfg  = tx_config_reg;
        end
        E_LO:    m_code = m_cfg[7:0];
        E_HI:    m_code = m_cfg[15:8];
        default: m_code = e.code;
      endcase
    end else if (m_frame) begin
      m_pkt = 1'b1;
      if (TX_EN && (mode == 2'b10)) begin
        m_code = TX_ER ? 8'hFE : TXD;
        m_k    = TX_ER;
      end else begin
        m_code = 8'hFD; m_k = 1'b1; m_frame = 1'b0;
        mq.push_back('{8'hF7, 1'b1, 1'b1, E_LIT});
        // The /R/ takes the parity of the slot on tx_code now; an even /R/ needs a twin.
        if (m_even) mq.push_back('{8'hF7, 1'b1, 1'b1, E_LIT});
      end
    end else if ((mode == 2'b10) && TX_EN && (rise || m_pend)) begin
      m_code = 8'hFB; m_k = 1'b1; m_pkt = 1'b1; m_frame = 1'b1;
    end else if (mode == 2'b00) begin
      m_code = 8'hBC; m_k = 1'b1; m_pkt = 1'b0;
      mq.push_back('{(m_c2 ? 8'h42 : 8'hB5), 1'b0, 1'b0, E_CFGC});
      mq.push_back('{8'h00, 1'b0, 1'b0, E_LO});
      mq.push_back('{8'h00, 1'b0, 1'b0, E_HI});
      m_c2 = !m_c2;
    end else begin
      m_code = 8'hBC; m_k = 1'b1; m_pkt = 1'b0; m_c2 = 1'b0;
      mq.push_back('{8'h00, 1'b0, 1'b0, E_IDLED});
    end
    m_pend    = npend;
    m_prev_en = TX_EN;
    m_even    = !m_even;
  endtask

  initial forever begin
    @(posedge GTX_CLK);
    model_step();
  end

  initial forever begin
    @(negedge GTX_CLK);
    if (chk_en) begin
      chk("code", 16'(tx_code), 16'(m_code));
      chk("is_k", 16'(tx_is_k), 16'(m_k));
      chk("even", 16'(tx_even), 16'(m_even));
      chk("pkt_active", 16'(tx_pkt_active), 16'(m_pkt));
    end
  end

  // Directed stimulus with an output log for literal checks.
  logic [7:0] oc[$];
  logic       okq[$];
  logic       oe[$];
  logic [7:0] eq[$];
  int         sop_idx;

  task automatic clear_log();
    oc.delete(); okq.delete(); oe.delete();
  endtask

  task automatic step(input logic en, input logic [7:0] d, input logic er);
    TX_EN = en; TXD = d; TX_ER = er;
    @(negedge GTX_CLK);
    oc.push_back(tx_code);
    okq.push_back(tx_is_k);
    oe.push_back(tx_even);
  endtask

  task automatic align(input logic want_even);
    int g;
    g = 0;
    step(1'b0, 8'h00, 1'b0);
    while (oe[$] !== want_even && g < 8) begin
      step(1'b0, 8'h00, 1'b0);
      g++;
    end
    if (oe[$] !== want_even) chk("align", 16'(oe[$]), 16'(want_even));
  endtask

  task automatic check_seq(input string name, input logic [7:0] first);
    int s;
    s = -1;
    for (int i = 0; i < oc.size(); i++) if (s < 0 && oc[i] == first) s = i;
    sop_idx = s;
    if (s < 0) begin
      chk({name, "_start_found"}, 16'h0000, 16'h0001);
      return;
    end
    for (int i = 0; i < eq.size(); i++) begin
      if (s + i >= oc.size()) begin
        chk({name, "_len"}, 16'hFFFF, 16'(eq[i]));
      end else begin
        chk({name, "_code"}, 16'(oc[s + i]), 16'(eq[i]));
        chk({name, "_k"}, 16'(okq[s + i]), 16'(is_k_code(eq[i])));
      end
    end
  endtask

  task automatic frame(input int n, input int er_idx, input logic odd);
    clear_log();
    align(odd);
    for (int i = 0; i < n; i++) step(1'b1, (i == n - 1) ? 8'hD5 : 8'h55, (i == er_idx));
    repeat (12) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  initial begin
    int g, fb_cnt;
    mr_main_reset = 1'b1; xmit = 2'b00; TXD = 8'h00; TX_EN = 1'b0; TX_ER = 1'b0;
    tx_config_reg = 16'h01A0; tx_disparity = 1'b0;
    repeat (2) @(negedge GTX_CLK);
    chk("rst_code", 16'(tx_code), 16'h00BC);
    chk("rst_k", 16'(tx_is_k), 16'h0001);
    chk("rst_even", 16'(tx_even), 16'h0001);
    chk("rst_pkt", 16'(tx_pkt_active), 16'h0000);
    mr_main_reset = 1'b0;

    // Configuration after reset: idle D completes the reset K, then /C1/ /C2/ alternate.
    clear_log();
    repeat (12) step(1'b0, 8'h00, 1'b0);
    chk("post_rst_idle_d", 16'(oc[0]), 16'h0050);
    chk("post_rst_odd", 16'(oe[0]), 16'h0000);
    eq = '{8'hBC, 8'hB5, 8'hA0, 8'h01, 8'hBC, 8'h42, 8'hA0, 8'h01, 8'hBC, 8'hB5};
    check_seq("cfg", 8'hBC);
    if (sop_idx >= 0) chk("cfg_first_even", 16'(oe[sop_idx]), 16'h0001);
    g = 0;
    while (oc[$] !== 8'hA0 && g < 8) begin step(1'b0, 8'h00, 1'b0); g++; end
    tx_config_reg = 16'h4321;
    step(1'b0, 8'h00, 1'b0);
    chk("cfg_hold_hi", 16'(oc[$]), 16'h0001);
    repeat (4) step(1'b0, 8'h00, 1'b0);

    // Idle in DATA mode with both disparities.
    xmit = 2'b10;
    repeat (6) step(1'b0, 8'h00, 1'b0);
    align(1'b1);
    chk("idle_k", 16'(oc[$]), 16'h00BC);
    step(1'b0, 8'h00, 1'b0);
    chk("idle_i2", 16'(oc[$]), 16'h0050);
    tx_disparity = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    chk("idle_k2", 16'(oc[$]), 16'h00BC);
    step(1'b0, 8'h00, 1'b0);
    chk("idle_i1", 16'(oc[$]), 16'h00C5);
    tx_disparity = 1'b0;
    repeat (2) step(1'b0, 8'h00, 1'b0);

    frame(8, -1, 1'b0);
    eq = '{8'hFB, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'hFD, 8'hF7, 8'hBC};
    check_seq("even_frame", 8'hFB);

    frame(8, -1, 1'b1);
    eq = '{8'hFB, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'hFD, 8'hF7, 8'hF7, 8'hBC};
    check_seq("odd_frame", 8'hFB);
    if (sop_idx > 0) chk("odd_pre_idle_d", 16'(oc[sop_idx - 1]), 16'h0050);

    frame(8, 2, 1'b0);
    eq = '{8'hFB, 8'h55, 8'hFE, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'hFD, 8'hF7, 8'hBC};
    check_seq("txer_frame", 8'hFB);

    frame(1, -1, 1'b0);
    eq = '{8'hFB, 8'hFD, 8'hF7, 8'hF7, 8'hBC};
    check_seq("pulse", 8'hFB);

    // TX_EN already high when DATA is entered must not start a frame.
    xmit = 2'b01;
    clear_log();
    repeat (4) step(1'b1, 8'h55, 1'b0);
    xmit = 2'b10;
    repeat (10) step(1'b1, 8'h55, 1'b0);
    fb_cnt = 0;
    foreach (oc[i]) if (oc[i] == 8'hFB) fb_cnt++;
    chk("no_late_start", 16'(fb_cnt), 16'h0000);
    repeat (3) step(1'b0, 8'h00, 1'b0);

    // xmit leaves DATA mid-frame.
    clear_log();
    align(1'b0);
    repeat (3) step(1'b1, 8'h55, 1'b0);
    xmit = 2'b00;
    repeat (9) step(1'b1, 8'h55, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b0);
    eq = '{8'hFB, 8'h55, 8'h55, 8'hFD, 8'hF7, 8'hF7, 8'hBC, 8'hB5};
    check_seq("xmit_switch", 8'hFB);
    if (sop_idx >= 0 && sop_idx + 6 < oe.size()) chk("xmit_switch_bc_even", 16'(oe[sop_idx + 6]), 16'h0001);
    xmit = 2'b10;
    repeat (8) step(1'b0, 8'h00, 1'b0);

    // Reset in the middle of a frame.
    clear_log();
    align(1'b0);
    repeat (3) step(1'b1, 8'h55, 1'b0);
    mr_main_reset = 1'b1;
    step(1'b1, 8'h55, 1'b0);
    chk("rst_mid_code", 16'(tx_code), 16'h00BC);
    chk("rst_mid_k", 16'(tx_is_k), 16'h0001);
    chk("rst_mid_pkt", 16'(tx_pkt_active), 16'h0000);
    chk("rst_mid_even", 16'(tx_even), 16'h0001);
    mr_main_reset = 1'b0;
    repeat (6) step(1'b0, 8'h00, 1'b0);

    summary();
    $finish;
  end

  initial begin
    #200000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected bench completion");
    summary();
    $finish;
  end

endmodule
